// File: rtl/multicycle_control.sv
// Main control FSM of the multicycle CPU: sequences fetch/decode/execute/memory/writeback and counts retired instructions.
// Optional feature: define ILLEGAL_TRAP_EN to trap unknown opcodes in TRAP instead of retiring them as NOPs.
module multicycle_control #(
  parameter int COUNT_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [6:0]         opcode,
  input  logic               zero,
  input  logic               mem_ready,
  output logic               pc_write,
  output logic               ir_write,
  output logic               mem_read,
  output logic               mem_write,
  output logic               i_or_d,
  output logic               reg_write,
  output logic               mem_to_reg,
  output logic               alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic               pc_source,
  output logic               ALUOp1,
  output logic               ALUOp0,
  output logic [3:0]         state,
  output logic [COUNT_W-1:0] retired,
  output logic               illegal
);

  typedef enum logic [3:0] {
    S_INIT      = 4'd0,
    S_FETCH     = 4'd1,
    S_DECODE    = 4'd2,
    S_MEM_ADDR  = 4'd3,
    S_MEM_READ  = 4'd4,
    S_MEM_WB    = 4'd5,
    S_MEM_WRITE = 4'd6,
    S_EXECUTE   = 4'd7,
    S_ALU_WB    = 4'd8,
    S_BRANCH    = 4'd9,
    S_TRAP      = 4'd10
  } state_t;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;

  typedef struct packed {
    logic       fetch;
    logic       branch;
    logic       mem_read;
    logic       mem_write;
    logic       i_or_d;
    logic       reg_write;
    logic       mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic       pc_source;
    logic [1:0] alu_op;
  } ctrl_t;

  state_t             state_q;
  ctrl_t              ctrl_q;
  logic [COUNT_W-1:0] retired_q;
  logic               nop_retire;

  function automatic logic known_op(input logic [6:0] op);
    return (op == OP_LW) || (op == OP_SW) || (op == OP_R) || (op == OP_BEQ);
  endfunction

  function automatic state_t next_state(input state_t s, input logic [6:0] op,
                                        input logic ready);
    state_t n;
    n = S_INIT;
    case (s)
      S_INIT:      n = S_FETCH;
      S_FETCH:     n = ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: n = S_MEM_ADDR;
          OP_R:         n = S_EXECUTE;
          OP_BEQ:       n = S_BRANCH;
`ifdef ILLEGAL_TRAP_EN
          default:      n = S_TRAP;
`else
          default:      n = S_FETCH;
`endif
        endcase
      end
      S_MEM_ADDR:  n = (op == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
      S_MEM_READ:  n = ready ? S_MEM_WB : S_MEM_READ;
      S_MEM_WB:    n = S_FETCH;
      S_MEM_WRITE: n = ready ? S_FETCH : S_MEM_WRITE;
      S_EXECUTE:   n = S_ALU_WB;
      S_ALU_WB:    n = S_FETCH;
      S_BRANCH:    n = S_FETCH;
      S_TRAP:      n = S_TRAP;
      default:     n = S_INIT;
    endcase
    return n;
  endfunction

  // Moore control word for a state; loaded together with the state so outputs come straight from flops.
  function automatic ctrl_t decode_ctrl(input state_t s);
    ctrl_t c;
    c = '0;
    case (s)
      S_FETCH: begin
        c.fetch     = 1'b1;
        c.mem_read  = 1'b1;
        c.alu_src_b = 2'b01;
      end
      S_DECODE:    c.alu_src_b = 2'b11;
      S_MEM_ADDR: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = 2'b10;
      end
      S_MEM_READ: begin
        c.mem_read = 1'b1;
        c.i_or_d   = 1'b1;
      end
      S_MEM_WB: begin
        c.reg_write  = 1'b1;
        c.mem_to_reg = 1'b1;
      end
      S_MEM_WRITE: begin
        c.mem_write = 1'b1;
        c.i_or_d    = 1'b1;
      end
      S_EXECUTE: begin
        c.alu_src_a = 1'b1;
        c.alu_op    = 2'b10;
      end
      S_ALU_WB:    c.reg_write = 1'b1;
      S_BRANCH: begin
        c.branch    = 1'b1;
        c.alu_src_a = 1'b1;
        c.alu_op    = 2'b01;
        c.pc_source = 1'b1;
      end
      default:     c = '0;
    endcase
    return c;
  endfunction

  function automatic logic retire_now(input state_t s, input logic ready,
                                      input logic nop);
    logic r;
    case (s)
      S_MEM_WB, S_ALU_WB, S_BRANCH: r = 1'b1;
      S_MEM_WRITE:                  r = ready;
      S_DECODE:                     r = nop;
      default:                      r = 1'b0;
    endcase
    return r;
  endfunction

`ifdef ILLEGAL_TRAP_EN
  assign nop_retire = 1'b0;
`else
  assign nop_retire = (state_q == S_DECODE) && !known_op(opcode);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_INIT;
      ctrl_q    <= '0;
      retired_q <= '0;
    end else begin
      state_q <= next_state(state_q, opcode, mem_ready);
      ctrl_q  <= decode_ctrl(next_state(state_q, opcode, mem_ready));
      if (retire_now(state_q, mem_ready, nop_retire))
        retired_q <= retired_q + 1'b1;
    end
  end

`ifdef ILLEGAL_TRAP_EN
  logic illegal_q;

  // Sticky: only reset clears it, and TRAP is never left without reset anyway.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      illegal_q <= 1'b0;
    else if (next_state(state_q, opcode, mem_ready) == S_TRAP)
      illegal_q <= 1'b1;
  end

  assign illegal = illegal_q;
`else
  assign illegal = 1'b0;
`endif

  // FETCH loads IR and PC+4 only on the cycle memory delivers; BRANCH loads PC only when equal.
  assign ir_write   = ctrl_q.fetch & mem_ready;
  assign pc_write   = (ctrl_q.fetch & mem_ready) | (ctrl_q.branch & zero);
  assign mem_read   = ctrl_q.mem_read;
  assign mem_write  = ctrl_q.mem_write;
  assign i_or_d     = ctrl_q.i_or_d;
  assign reg_write  = ctrl_q.reg_write;
  assign mem_to_reg = ctrl_q.mem_to_reg;
  assign alu_src_a  = ctrl_q.alu_src_a;
  assign alu_src_b  = ctrl_q.alu_src_b;
  assign pc_source  = ctrl_q.pc_source;
  assign ALUOp1     = ctrl_q.alu_op[1];
  assign ALUOp0     = ctrl_q.alu_op[0];
  assign state      = state_q;
  assign retired    = retired_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed-vector bench for multicycle_control (built with COUNT_W=4 so counter wrap is reachable quickly).
module tb_multicycle_control;

  localparam int CW = 4;
  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_BAD = 7'b1111111;

  logic          clk = 1'b0;
  logic          rst;
  logic [6:0]    opcode;
  logic          zero;
  logic          mem_ready;
  logic          pc_write, ir_write, mem_read, mem_write, i_or_d;
  logic          reg_write, mem_to_reg, alu_src_a, pc_source, ALUOp1, ALUOp0;
  logic [1:0]    alu_src_b;
  logic [3:0]    state;
  logic [CW-1:0] retired;
  logic          illegal;

  int            checkCount = 0;
  int            passCount  = 0;
  logic [CW-1:0] expRetired;
  logic          overlap;

  multicycle_control #(.COUNT_W(CW)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .pc_write(pc_write), .ir_write(ir_write), .mem_read(mem_read),
    .mem_write(mem_write), .i_or_d(i_or_d), .reg_write(reg_write),
    .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .pc_source(pc_source), .ALUOp1(ALUOp1), .ALUOp0(ALUOp0), .state(state),
    .retired(retired), .illegal(illegal)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [15:0] got,
                             input logic [15:0] exp);
    checkCount++;
    if (got === exp)
      passCount++;
    else
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Inputs change just after the falling edge; outputs are checked 1 time unit later.
  task automatic applyStimulus(input logic [6:0] op, input logic ready,
                               input logic z);
    opcode    = op;
    mem_ready = ready;
    zero      = z;
    #1;
    if (mem_read && mem_write) overlap = 1'b1;
  endtask

  task automatic nextCycle();
    @(negedge clk);
  endtask

  task automatic runSw();
    for (int c = 0; c < 4; c++) begin
      applyStimulus(OP_SW, 1'b1, 1'b0);
      nextCycle();
    end
  endtask

  initial begin
    overlap    = 1'b0;
    expRetired = '0;
    rst        = 1'b1;
    opcode     = '0;
    zero       = 1'b0;
    mem_ready  = 1'b0;
    nextCycle();
    nextCycle();
    #1;
    checkOutput("reset_state", 16'(state), 16'd0);
    checkOutput("reset_retired", 16'(retired), 16'd0);
    checkOutput("reset_illegal", 16'(illegal), 16'd0);
    checkOutput("reset_mem_read", 16'(mem_read), 16'd0);
    rst = 1'b0;
    nextCycle();

    // FETCH waiting on memory: no IR/PC load, state holds
    applyStimulus(OP_R, 1'b0, 1'b0);
    checkOutput("fetch_state", 16'(state), 16'd1);
    checkOutput("fetch_wait_ir_write", 16'(ir_write), 16'd0);
    checkOutput("fetch_mem_read", 16'(mem_read), 16'd1);
    nextCycle();

    // R-type: states 1,2,7,8
    applyStimulus(OP_R, 1'b1, 1'b0);
    checkOutput("r_fetch_state", 16'(state), 16'd1);
    checkOutput("r_fetch_ir_pc", 16'({ir_write, pc_write, alu_src_b}), 16'b1101);
    nextCycle();
    applyStimulus(OP_R, 1'b1, 1'b0);
    checkOutput("r_decode", 16'({state, alu_src_b, alu_src_a}), 16'b0010_11_0);
    nextCycle();
    applyStimulus(OP_R, 1'b1, 1'b0);
    checkOutput("r_execute", 16'({state, ALUOp1, ALUOp0, reg_write, alu_src_a, alu_src_b}),
                16'b0111_10_0_1_00);
    nextCycle();
    applyStimulus(OP_R, 1'b1, 1'b0);
    checkOutput("r_alu_wb", 16'({state, reg_write, mem_to_reg}), 16'b1000_1_0);
    nextCycle();
    expRetired = expRetired + 1'b1;
    applyStimulus(OP_LW, 1'b1, 1'b0);
    checkOutput("r_done", 16'({state, retired}), 16'({4'd1, expRetired}));

    // lw with three not-ready cycles in MEM_READ
    nextCycle();
    applyStimulus(OP_LW, 1'b1, 1'b0);
    nextCycle();
    applyStimulus(OP_LW, 1'b1, 1'b0);
    checkOutput("lw_mem_addr", 16'({state, alu_src_a, alu_src_b}), 16'b0011_1_10);
    nextCycle();
    for (int c = 0; c < 3; c++) begin
      applyStimulus(OP_LW, 1'b0, 1'b0);
      checkOutput("lw_mem_read_wait", 16'({state, mem_read, i_or_d, mem_write}),
                  16'b0100_1_1_0);
      nextCycle();
    end
    applyStimulus(OP_LW, 1'b1, 1'b0);
    checkOutput("lw_mem_read_last", 16'(state), 16'd4);
    nextCycle();
    applyStimulus(OP_LW, 1'b1, 1'b0);
    checkOutput("lw_mem_wb", 16'({state, reg_write, mem_to_reg}), 16'b0101_1_1);
    nextCycle();
    expRetired = expRetired + 1'b1;
    applyStimulus(OP_BEQ, 1'b1, 1'b0);
    checkOutput("lw_done", 16'({state, retired}), 16'({4'd1, expRetired}));

    // beq taken then not taken
    for (int t = 0; t < 2; t++) begin
      nextCycle();
      applyStimulus(OP_BEQ, 1'b1, 1'b0);
      nextCycle();
      applyStimulus(OP_BEQ, 1'b1, (t == 0));
      checkOutput("beq_branch", 16'({state, pc_write, ALUOp1, ALUOp0, pc_source}),
                  16'({4'd9, (t == 0), 2'b01, 1'b1}));
      nextCycle();
      expRetired = expRetired + 1'b1;
      applyStimulus(OP_BEQ, 1'b1, 1'b0);
      checkOutput("beq_done", 16'({state, retired}), 16'({4'd1, expRetired}));
    end

    // Reset in the middle of a stalled MEM_READ
    nextCycle();
    applyStimulus(OP_LW, 1'b1, 1'b0);
    nextCycle();
    applyStimulus(OP_LW, 1'b0, 1'b0);
    nextCycle();
    applyStimulus(OP_LW, 1'b0, 1'b0);
    checkOutput("pre_reset_mem_read", 16'(state), 16'd4);
    rst = 1'b1;
    #1;
    checkOutput("async_reset", 16'({state, mem_read, retired}), 16'd0);
    nextCycle();
    rst = 1'b0;
    expRetired = '0;
    applyStimulus(OP_SW, 1'b1, 1'b0);
    checkOutput("after_reset_init", 16'(state), 16'd0);
    nextCycle();

    // 16 back-to-back sw: counter wraps through 15 to 0
    overlap = 1'b0;
    for (int i = 0; i < 15; i++) runSw();
    #1;
    checkOutput("sw_retired_15", 16'({state, retired}), 16'({4'd1, 4'd15}));
    runSw();
    #1;
    checkOutput("sw_retired_wrap", 16'({state, retired}), 16'({4'd1, 4'd0}));
    checkOutput("sw_no_overlap", 16'(overlap), 16'd0);

    // Unknown opcode
    applyStimulus(OP_BAD, 1'b1, 1'b0);
    nextCycle();
    applyStimulus(OP_BAD, 1'b1, 1'b0);
    checkOutput("bad_decode", 16'(state), 16'd2);
    nextCycle();
`ifdef ILLEGAL_TRAP_EN
    for (int c = 0; c < 3; c++) begin
      applyStimulus(OP_BAD, 1'b1, 1'b1);
      checkOutput("trap_hold", 16'({state, illegal, retired, mem_read, mem_write,
                                    pc_write, ir_write, reg_write}),
                  16'({4'd10, 1'b1, 4'd0, 5'b00000}));
      nextCycle();
    end
`else
    applyStimulus(OP_BAD, 1'b1, 1'b0);
    checkOutput("nop_retire", 16'({state, illegal, retired}), 16'({4'd1, 1'b0, 4'd1}));
    nextCycle();
`endif

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
